// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: MULT/MULTU take 1 busy cycle, DIV/DIVU take 33 (32 steps + sign fixup), MTHI/MTLO write at issue.
// No backpressure inside: isbusy tells the stall unit to hold issue; starts seen while busy or flushing are dropped.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        isbusy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mul_signed;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [5:0]  count;

    logic        issue;
    logic        issue_mul;
    logic        issue_div;
    logic        div_signed;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;

    assign issue      = start && !flush && (state == S_IDLE);
    assign issue_mul  = issue && ((op == OP_MULT) || (op == OP_MULTU));
    assign issue_div  = issue && ((op == OP_DIV) || (op == OP_DIVU));
    assign div_signed = (op == OP_DIV);
    assign abs_rs     = (div_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    assign abs_rt     = (div_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

    // Shifted partial remainder can reach 33 bits; the subtraction borrow doubles as the compare.
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    assign shifted  = {rem, quo[31]};
    assign diff     = shifted - {1'b0, op_b};
    assign ge       = ~diff[32];
    assign rem_step = ge ? diff[31:0] : shifted[31:0];
    assign quo_step = {quo[30:0], ge};

    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic        [63:0] product;

    assign mul_a   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    assign mul_b   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    assign product = mul_a * mul_b;

    // A zero divisor bypasses sign fixup and returns the raw dividend in HI.
    logic        div_zero;
    logic [31:0] lo_fix;
    logic [31:0] hi_fix;

    assign div_zero = (op_b == 32'd0);
    assign lo_fix   = div_zero ? 32'hFFFF_FFFF : (q_neg ? (~quo + 32'd1) : quo);
    assign hi_fix   = div_zero ? op_a : (r_neg ? (~rem + 32'd1) : rem);

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_mul) begin
                        state_nxt = S_MUL;
                    end else if (issue_div) begin
                        state_nxt = S_DIV;
                    end
                end
                S_MUL:   state_nxt = S_IDLE;
                S_DIV:   state_nxt = (count == 6'd31) ? S_FIX : S_DIV;
                S_FIX:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            isbusy <= 1'b0;
        end else begin
            state  <= state_nxt;
            isbusy <= (state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            rem        <= 32'd0;
            quo        <= 32'd0;
            count      <= 6'd0;
        end else if (issue_mul) begin
            op_a       <= rs_val;
            op_b       <= rt_val;
            mul_signed <= (op == OP_MULT);
        end else if (issue_div) begin
            op_a  <= rs_val;
            op_b  <= abs_rt;
            q_neg <= div_signed && (rs_val[31] ^ rt_val[31]);
            r_neg <= div_signed && rs_val[31];
            rem   <= 32'd0;
            quo   <= abs_rs;
            count <= 6'd0;
        end else if (flush) begin
            count <= 6'd0;
        end else if (state == S_DIV) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (!flush) begin
            if (issue && (op == OP_MTHI)) begin
                HI <= rs_val;
            end
            if (issue && (op == OP_MTLO)) begin
                LO <= rs_val;
            end
            if (state == S_MUL) begin
                HI <= product[63:32];
                LO <= product[31:0];
            end
            if (state == S_FIX) begin
                HI <= hi_fix;
                LO <= lo_fix;
            end
        end
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multiply/divide responder for the EX stage; owns the HI/LO register pair and produces the `isbusy` signal that the pipeline stall unit combines with `RHL_visit` to hold MFHI/MFLO and following multiply/divide ops. Multiplies complete in one busy cycle; divides run a 32-iteration restoring divider plus one sign-fixup cycle. MTHI/MTLO write immediately without asserting busy. A flush input cancels in-flight work on exception or ERET.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  issue strobe from EX; sampled only when `isbusy`=0 and `flush`=0.
- op  in  3  3'd0 MULT, 3'd1 MULTU, 3'd2 DIV, 3'd3 DIVU, 3'd4 MTHI, 3'd5 MTLO; 3'd6–7 no-op.
- rs_val  in  32  operand A (dividend / multiplicand / MT source).
- rt_val  in  32  operand B (divisor / multiplier).
- flush  in  1  driven by MEM_ex | MEM_eret_flush; aborts current operation.
- isbusy  out  1  registered; 1 whenever state ≠ IDLE.
- HI  out  32  registered HI.
- LO  out  32  registered LO.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + start, no flush:
  - MULT/MULTU: latch operands and signedness → MUL.
  - DIV/DIVU: latch |rs|, |rt| (magnitudes only for DIV), quotient sign = rs[31]^rt[31], remainder sign = rs[31]; clear 6-bit counter → DIV.
  - MTHI: HI←rs_val. MTLO: LO←rs_val. Stay IDLE.
  - op 6–7: ignored.
- MUL: {HI,LO}←64-bit product. Signed for MULT, unsigned for MULTU. → IDLE.
- DIV: one restoring step per cycle on a 64-bit {rem,quo} shift register.
  - Shift left 1.
  - If rem[31:0] ≥ divisor: subtract, set quo bit 0.
  - Counter increments; after the 32nd step → FIX.
- FIX: LO←quotient, negated if quotient sign set (DIV only). HI←remainder, negated if remainder sign set (DIV only). → IDLE.
- Divide by zero: no exception, fixed result. LO=32'hFFFFFFFF, HI=rs_val as latched (raw operand, no sign handling).
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Falls out of the magnitude algorithm.
- flush in any state: next state IDLE, counter cleared, HI/LO not written.
- flush in IDLE with start: start ignored, including MTHI/MTLO.
- start while busy: ignored. The stall unit guarantees this does not occur in normal operation.
- Operands are latched at issue; later changes on rs_val/rt_val have no effect.

## Timing
- Reset (async): state=IDLE, isbusy=0, HI=0, LO=0, counter=0, operand registers 0.
- Start sampled at edge N. isbusy rises after edge N.
- MULT/MULTU:
  - isbusy=1 for exactly one cycle (N..N+1).
  - HI/LO updated at edge N+1; isbusy=0 after N+1.
- DIV/DIVU:
  - isbusy=1 for 33 cycles: 32 DIV + 1 FIX.
  - HI/LO updated at edge N+33; isbusy=0 after N+33.
- MTHI/MTLO: HI/LO updated at edge N; isbusy stays 0.
- HI/LO change only at a MUL, FIX or MT edge; stable otherwise.
- Back-to-back: a new start is accepted at the first edge where isbusy=0.
- No combinational path from inputs to any output.

## Test plan
- Reset asserted mid-DIV (counter=10) → isbusy, HI, LO immediately 0; next DIVU 100/7 gives LO=14, HI=2 at N+33.
- MULT rs=0xFFFFFFFB (−5), rt=3 → isbusy high exactly one cycle; HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → isbusy high 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=0x12345678, rt=0 → after 33 cycles LO=0xFFFFFFFF, HI=0x12345678.
- HI=0xAAAA_AAAA pre-set via MTHI; start DIV; flush at cycle 5 → isbusy=0 next cycle, HI still 0xAAAA_AAAA. start+flush in same cycle with MTLO 0x55 → LO unchanged.
- MTLO 0x1234 → LO=0x1234 after one edge, isbusy never 1. MULT issued on the cycle isbusy falls after a DIV → accepted, result at +1 edge.
